// File: rtl/accumulator_serial_if.sv
// Request/status bundle for accumulator_serial: the master issues operations, the slave
// reports progress and the accumulator contents.
interface accumulator_serial_if #(
  parameter int unsigned WORD_BITS = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [WORD_BITS-1:0] operand;
  logic                 busy;
  logic                 done;
  logic [WORD_BITS-1:0] acc;
  logic                 negative;
  logic                 overflow;

  modport master (
    output start, op, operand,
    input  busy, done, acc, negative, overflow
  );

  modport slave (
    input  start, op, operand,
    output busy, done, acc, negative, overflow
  );
endinterface

// File: rtl/accumulator_serial.sv
// Serial accumulator: computes A = 0 - S or A = A - S one SLICE_BITS slice per cycle and
// commits the whole result in one step. Define ACC_OVERFLOW_EN to enable the overflow flag.
module accumulator_serial #(
  parameter int unsigned WORD_BITS  = 32,
  parameter int unsigned SLICE_BITS = 8
) (
  input logic                clock,
  input logic                reset,
  accumulator_serial_if.slave bus
);
  localparam int unsigned N        = WORD_BITS / SLICE_BITS;
  localparam int unsigned IDX_BITS = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LSB_BITS = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [1:0]  OP_LDN   = 2'b01;
  localparam logic [1:0]  OP_SUB   = 2'b10;
  localparam logic [1:0]  OP_CLR   = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [WORD_BITS-1:0]   acc_q;
  logic [WORD_BITS-1:0]   minuend;
  logic [WORD_BITS-1:0]   subtrahend;
  logic [WORD_BITS-1:0]   result;
  logic [WORD_BITS-1:0]   result_next;
  logic                   borrow;
  logic [IDX_BITS-1:0]    idx;
  logic                   busy_q;
  logic                   done_q;
  logic [LSB_BITS-1:0]    lsb;
  logic [SLICE_BITS-1:0]  m_slice;
  logic [SLICE_BITS-1:0]  s_slice;
  logic [SLICE_BITS:0]    diff;

  // Current slice difference, with the borrow-out landing in the extra top bit.
  always_comb begin
    lsb         = LSB_BITS'(32'(idx) * SLICE_BITS);
    m_slice     = minuend[lsb +: SLICE_BITS];
    s_slice     = subtrahend[lsb +: SLICE_BITS];
    diff        = {1'b0, m_slice} - {1'b0, s_slice} - {{SLICE_BITS{1'b0}}, borrow};
    result_next = result;
    result_next[lsb +: SLICE_BITS] = diff[SLICE_BITS-1:0];
  end

`ifdef ACC_OVERFLOW_EN
  logic overflow_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      acc_q      <= '0;
      minuend    <= '0;
      subtrahend <= '0;
      result     <= '0;
      borrow     <= 1'b0;
      idx        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ACC_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (bus.op == OP_LDN || bus.op == OP_SUB)) begin
            minuend    <= (bus.op == OP_SUB) ? acc_q : '0;
            subtrahend <= bus.operand;
            borrow     <= 1'b0;
            idx        <= '0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end else if (bus.start && bus.op == OP_CLR) begin
            acc_q      <= '0;
`ifdef ACC_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        RUN: begin
          result <= result_next;
          borrow <= diff[SLICE_BITS];
          idx    <= idx + IDX_BITS'(1);
          // acc only moves on the final slice so observers never see a partial result.
          if (idx == IDX_BITS'(N - 1)) begin
            acc_q      <= result_next;
`ifdef ACC_OVERFLOW_EN
            overflow_q <= (minuend[WORD_BITS-1] != subtrahend[WORD_BITS-1]) &&
                          (result_next[WORD_BITS-1] != minuend[WORD_BITS-1]);
`endif
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.acc      = acc_q;
  assign bus.negative = acc_q[WORD_BITS-1];
`ifdef ACC_OVERFLOW_EN
  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: doc/accumulator_serial.md
ACCUMULATOR_SERIAL -- requirements
Module: accumulator_serial

Interface
REQ-001 SHALL have parameter WORD_BITS, default 32, meaning the accumulator and operand width.
REQ-002 SHALL have parameter SLICE_BITS, default 8, meaning the width of the subtraction slice processed per cycle; legal values 1, 2, 4, 8, 16, 32; WORD_BITS divisible by SLICE_BITS.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-006 SHALL have port op  input  2  operation: 00 NOP, 01 LDN (A = 0 - S), 10 SUB (A = A - S), 11 CLR (A = 0).
REQ-007 SHALL have port operand  input  WORD_BITS  subtrahend S, latched when start is accepted.
REQ-008 SHALL have port busy  output  1  high while slices are being processed.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port acc  output  WORD_BITS  accumulator register.
REQ-011 SHALL have port negative  output  1  equal to acc[WORD_BITS-1], combinational from acc.
REQ-012 SHALL have port overflow  output  1  signed-overflow flag (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; N = WORD_BITS/SLICE_BITS.
REQ-014 In IDLE with start=1 and op in {LDN, SUB}: latch minuend (0 for LDN, acc for SUB), latch operand, clear slice borrow, slice index = 0, go to RUN.
REQ-015 In IDLE with start=1 and op=CLR: acc <= 0 on that edge, go to DONE; no RUN cycles.
REQ-016 In IDLE with start=1 and op=NOP, or start=0: stay in IDLE, no output change.
REQ-017 Each RUN cycle SHALL compute slice = minuend_slice - S_slice - borrow, register the slice into a shadow result, register borrow-out as next borrow, increment index.
REQ-018 SHALL use two's-complement wrap-around arithmetic; borrow out of the top slice is discarded.
REQ-019 On the RUN edge processing slice N-1: acc <= full shadow result atomically, go to DONE; acc SHALL NOT change during intermediate RUN cycles.
REQ-020 Latency: start accepted at edge E0 -> acc updated at edge E0+N -> done high for exactly the cycle after E0+N; CLR -> done high in the cycle after E0.
REQ-021 DONE SHALL last one cycle, then return to IDLE; done = (state==DONE); busy = (state==RUN).
REQ-022 start asserted in RUN or DONE SHALL be ignored (not queued); operand changes after acceptance SHALL not affect the result.
REQ-023 SLICE_BITS = WORD_BITS SHALL give N = 1 (single RUN cycle).

Reset
REQ-024 On reset=1 at a clock edge: state <= IDLE, acc <= 0, overflow <= 0, borrow <= 0, index <= 0; busy=0, done=0, negative=0 from the next cycle.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse and no partial acc update; reset SHALL take priority over start.

Configuration
REQ-026 Macro ACC_OVERFLOW_EN defined: overflow <= (minuend sign != S sign) and (result sign != minuend sign), updated with acc on commit, cleared by CLR and reset.
REQ-027 Macro ACC_OVERFLOW_EN undefined: overflow port present, driven constant 0, no overflow logic synthesised.

Verification (WORD_BITS=32, SLICE_BITS=8, N=4)
REQ-028 Reset, then LDN operand=0x00000005 -> busy 4 cycles, acc=0xFFFFFFFB, negative=1, done pulse once at cycle 4 after start.
REQ-029 acc=0x00000100, SUB operand=0x00000001 -> acc=0x000000FF (borrow across slice boundary), negative=0.
REQ-030 acc=0x80000000, SUB operand=0x00000001 -> acc=0x7FFFFFFF; overflow=1 with ACC_OVERFLOW_EN, 0 without.
REQ-031 SUB started, start re-asserted with op=CLR during RUN -> ignored; result as for SUB alone, single done pulse.
REQ-032 acc=0x12345678, SUB started, reset asserted 2 cycles later -> acc=0, busy=0, no done pulse; next LDN 0 -> acc=0x00000000.
REQ-033 acc=0xDEADBEEF, CLR -> acc=0 on accepting edge, done high next cycle, busy never asserted.
